// File: rtl/toggle_monitor.sv
// Watches a toggling signal A and its complement B: counts rises, measures half periods,
// flags a stuck A and a sticky A/B complement violation. Outputs lag A by two clocks after capture.
module toggle_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             clear,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             mismatch,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  logic             r_sa1, r_sa2, r_sa3;
  logic             r_sb1, r_sb2;
  logic [1:0]       r_fill;
  logic             r_eq_prev;
  state_t           r_state;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_rise_count;
  logic [CNT_W-1:0] r_half_period;
  logic             r_period_valid;
  logic             r_mismatch;
  logic             r_stuck;

  logic             w_edge;
  logic             w_rise;
  logic             w_eq_now;
  logic [CNT_W-1:0] w_cyc_inc;

  assign w_edge    = r_sa2 != r_sa3;
  assign w_rise    = r_sa2 & ~r_sa3;
  // Both synchronizers reset to 0, so A==B there until real samples have propagated.
  assign w_eq_now  = r_fill[1] & (r_sa2 == r_sb2);
  assign w_cyc_inc = (r_cyc == MAX_CNT) ? r_cyc : r_cyc + ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sa1  <= 1'b0;
      r_sa2  <= 1'b0;
      r_sa3  <= 1'b0;
      r_sb1  <= 1'b0;
      r_sb2  <= 1'b0;
      r_fill <= 2'b00;
    end else begin
      r_sa1  <= A;
      r_sa2  <= r_sa1;
      r_sa3  <= r_sa2;
      r_sb1  <= B;
      r_sb2  <= r_sb1;
      r_fill <= {r_fill[0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_state        <= IDLE;
      r_cyc          <= '0;
      r_rise_count   <= '0;
      r_half_period  <= '0;
      r_period_valid <= 1'b0;
      r_mismatch     <= 1'b0;
      r_stuck        <= 1'b0;
      r_eq_prev      <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      r_eq_prev      <= w_eq_now;
      if (w_rise)
        r_rise_count <= r_rise_count + ONE;
      if (w_eq_now && r_eq_prev)
        r_mismatch <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_state <= MEASURE;
            r_cyc   <= ONE;
          end
        end
        MEASURE: begin
          if (w_edge) begin
            r_half_period  <= r_cyc;
            r_period_valid <= 1'b1;
            r_cyc          <= ONE;
          end else if (r_cyc == TO_CNT) begin
            r_state <= STUCK;
            r_stuck <= 1'b1;
          end else begin
            r_cyc <= w_cyc_inc;
          end
        end
        STUCK: begin
          // Interval spanning a stuck period is meaningless, so no report here.
          if (w_edge) begin
            r_state <= MEASURE;
            r_stuck <= 1'b0;
            r_cyc   <= ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rise_count   = r_rise_count;
  assign half_period  = r_half_period;
  assign period_valid = r_period_valid;
  assign mismatch     = r_mismatch;
  assign stuck        = r_stuck;

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor: three instances with different CNT_W/TIMEOUT share stimulus.
module tb_toggle_monitor;

  logic clock, reset, A, B, clear;

  logic [15:0] rc16, hp16;
  logic        pv16, mm16, st16;
  logic [15:0] rc8, hp8;
  logic        pv8, mm8, st8;
  logic [3:0]  rc4, hp4;
  logic        pv4, mm4, st4;

  int total = 0;
  int bad   = 0;
  int pvc, first_pv, big;

  toggle_monitor #(.CNT_W(16), .TIMEOUT(1000)) dut16 (
    .clock(clock), .reset(reset), .A(A), .B(B), .clear(clear),
    .rise_count(rc16), .half_period(hp16), .period_valid(pv16),
    .mismatch(mm16), .stuck(st16)
  );

  toggle_monitor #(.CNT_W(16), .TIMEOUT(8)) dut8 (
    .clock(clock), .reset(reset), .A(A), .B(B), .clear(clear),
    .rise_count(rc8), .half_period(hp8), .period_valid(pv8),
    .mismatch(mm8), .stuck(st8)
  );

  toggle_monitor #(.CNT_W(4), .TIMEOUT(15)) dut4 (
    .clock(clock), .reset(reset), .A(A), .B(B), .clear(clear),
    .rise_count(rc4), .half_period(hp4), .period_valid(pv4),
    .mismatch(mm4), .stuck(st4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    A     = 1'b0;
    B     = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
  endtask

  task automatic toggle();
    A = ~A;
    B = ~A;
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    A     = 1'b0;
    B     = 1'b1;
    step(2);
    chk("rst_rc",  32'(rc16), 0);
    chk("rst_hp",  32'(hp16), 0);
    chk("rst_pv",  32'(pv16), 0);
    chk("rst_mm",  32'(mm16), 0);
    chk("rst_st",  32'(st16), 0);
    chk("rst_rc4", 32'(rc4),  0);

    // Toggle every 5 cycles, 10 edges
    do_reset();
    pvc = 0;
    first_pv = 0;
    for (int e = 0; e < 10; e++) begin
      toggle();
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (pv16) begin
          pvc++;
          if (e == 0) first_pv++;
          chk("tog_hp", 32'(hp16), 5);
        end
      end
    end
    chk("tog_first_pv", first_pv, 0);
    chk("tog_pv_cnt", pvc, 9);
    chk("tog_rc", 32'(rc16), 5);
    chk("tog_mm", 32'(mm16), 0);
    chk("tog_st", 32'(st16), 0);

    // Timeout with TIMEOUT=8
    do_reset();
    step(2);
    toggle();
    step(3);
    chk("to_pre", 32'(st8), 0);
    step(7);
    chk("to_st_7", 32'(st8), 0);
    step(1);
    chk("to_st_8", 32'(st8), 1);
    step(4);
    chk("to_st_hold", 32'(st8), 1);
    toggle();
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("to_recover_pv", 32'(pv8), 0);
    end
    chk("to_st_clr", 32'(st8), 0);
    step(3);
    toggle();
    step(2);
    chk("to_next_pv0", 32'(pv8), 0);
    step(1);
    chk("to_next_pv1", 32'(pv8), 1);
    chk("to_next_hp", 32'(hp8), 6);

    // Mismatch: 1-cycle skew tolerated, 3 cycles latched
    do_reset();
    step(3);
    B = 1'b0;
    step(1);
    B = 1'b1;
    step(6);
    chk("mm_1cyc", 32'(mm16), 0);
    B = 1'b0;
    step(3);
    B = 1'b1;
    step(4);
    chk("mm_3cyc", 32'(mm16), 1);
    step(5);
    chk("mm_sticky", 32'(mm16), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("mm_clear", 32'(mm16), 0);
    step(4);
    chk("mm_after_clear", 32'(mm16), 0);

    // Wrap with CNT_W=4, then stuck on 20-cycle half period
    do_reset();
    for (int i = 0; i < 34; i++) begin
      toggle();
      step(2);
    end
    step(3);
    chk("wrap_rc", 32'(rc4), 1);
    chk("wrap_hp", 32'(hp4), 2);
    big = 0;
    for (int i = 0; i < 3; i++) begin
      toggle();
      for (int c = 0; c < 20; c++) begin
        step(1);
        if (pv4 && hp4 > 4'd15) big++;
      end
      chk("wrap_stuck", 32'(st4), 1);
    end
    chk("wrap_big_hp", big, 0);
    chk("wrap_last_hp", 32'(hp4), 5);

    // Clear colliding with a rise
    do_reset();
    toggle();
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_rc", 32'(rc16), 0);
    chk("clr_pv", 32'(pv16), 0);
    chk("clr_st", 32'(st16), 0);
    step(4);
    toggle();
    pvc = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (pv16) pvc++;
    end
    chk("clr_idle_edge_pv", pvc, 0);
    toggle();
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (pv16) begin
        pvc++;
        chk("clr_resume_hp", 32'(hp16), 5);
      end
    end
    chk("clr_resume_pv", pvc, 1);
    chk("clr_resume_rc", 32'(rc16), 1);

    // Reset mid-measurement, A toggling every 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      toggle();
      step(3);
    end
    toggle();
    step(1);
    chk("rm_pre_hp", 32'(hp16), 3);
    chk("rm_pre_rc", 32'(rc16), 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rm_rc", 32'(rc16), 0);
    chk("rm_hp", 32'(hp16), 0);
    chk("rm_pv", 32'(pv16), 0);
    chk("rm_mm", 32'(mm16), 0);
    chk("rm_st", 32'(st16), 0);
    step(1);
    toggle();
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("rm_first_edge_pv", 32'(pv16), 0);
    end
    toggle();
    step(2);
    chk("rm_second_pv0", 32'(pv16), 0);
    step(1);
    chk("rm_second_pv1", 32'(pv16), 1);
    chk("rm_second_hp", 32'(hp16), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
